// File: rtl/control_pipe_pkg.sv
// ctrl_pkg: shared types and constants for the pipelined control unit.
//   ctrl_t       full decoded control word as held in ID/EX (plus illegal flag)
//   mem_ctrl_t   subset carried in EX/MEM
//   wb_ctrl_t    subset carried in MEM/WB
//   mem_state_t  data-memory wait FSM states
package ctrl_pkg;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef struct packed {
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [1:0] memtoreg;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] memtoreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE = '0;
    localparam mem_ctrl_t MEM_BUBBLE  = '0;
    localparam wb_ctrl_t  WB_BUBBLE   = '0;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        mem_ctrl_t m;
        m.regwrite = c.regwrite;
        m.memread  = c.memread;
        m.memwrite = c.memwrite;
        m.memtoreg = c.memtoreg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.regwrite = m.regwrite;
        w.memtoreg = m.memtoreg;
        return w;
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// control_pipe_if: bundles the ID-stage inputs, stall sources and per-stage
// control outputs of control_pipe.
//   slave  : the control unit (consumes opcode/stalls, drives control bits)
//   master : whatever feeds it (IF/ID, hazard unit, data memory, datapath)
interface control_pipe_if #(
    parameter int ALUOP_W = 2
);
    logic [6:0]         opcode;
    logic               hazard_stall;
    logic               branch_taken;
    logic               mem_ready;

    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_illegal;
    logic               mem_memread;
    logic               mem_memwrite;
    logic               wb_regwrite;
    logic [1:0]         wb_memtoreg;
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               mem_busy;
    logic               mem_timeout;

    modport slave (
        input  opcode, hazard_stall, branch_taken, mem_ready,
        output ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_illegal,
               mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg,
               pc_write, ifid_write, ifid_flush, mem_busy, mem_timeout
    );

    modport master (
        output opcode, hazard_stall, branch_taken, mem_ready,
        input  ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_illegal,
               mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg,
               pc_write, ifid_write, ifid_flush, mem_busy, mem_timeout
    );

endinterface

// File: rtl/control_pipe_decode.sv
// control_decode: combinational opcode -> control word.
//   opcode  in   7-bit ID-stage opcode
//   ctrl    out  decoded ctrl_t; unknown opcodes give an all-zero word with illegal=1
// EXT_OPS=0 treats jal/jalr/lui as unknown.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    localparam bit EXT_EN = (EXT_OPS != 0);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_NOP: ctrl = CTRL_BUBBLE;
            OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = MEMTOREG_MEM;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_RTYPE;
            end
            OP_ITYPE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_ITYPE;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.aluop    = ALUOP_BRANCH;
            end
            OP_JAL: begin
                if (EXT_EN) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.memtoreg = MEMTOREG_PC4;
                end else begin
                    ctrl.illegal  = 1'b1;
                end
            end
            OP_JALR: begin
                if (EXT_EN) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.memtoreg = MEMTOREG_PC4;
                end else begin
                    ctrl.illegal  = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_EN) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                end else begin
                    ctrl.illegal  = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: pipelined RISC-V control unit.
// Decodes the ID opcode and carries the control word through ID/EX, EX/MEM
// and MEM/WB, handling load-use bubbles, branch flush and a data-memory wait
// with timeout.
//   clk, rst_n   clock (rising edge), async active-low reset
//   bus (slave)  opcode, hazard_stall, branch_taken, mem_ready in;
//                ex_*, mem_*, wb_* stage controls, pc_write, ifid_write,
//                ifid_flush, mem_busy, mem_timeout out
//
// Memory FSM:
//   state    | meaning
//   MEM_IDLE | no outstanding access, or a zero-latency one completing now
//   MEM_WAIT | EX/MEM memory op waiting for mem_ready; counter = cycles waited
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int EXT_OPS     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    control_pipe_if.slave bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    ctrl_t      id_ctrl;
    ctrl_t      idex_q,  idex_d;
    mem_ctrl_t  exmem_q, exmem_d;
    wb_ctrl_t   memwb_q, memwb_d;
    mem_state_t state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;

    logic mem_op;
    logic timeout_hit;
    logic freeze;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;

    control_decode #(
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .opcode (bus.opcode),
        .ctrl   (id_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= CTRL_BUBBLE;
            exmem_q <= MEM_BUBBLE;
            memwb_q <= WB_BUBBLE;
            state_q <= MEM_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_op      = exmem_q.memread | exmem_q.memwrite;
        timeout_hit = (state_q == MEM_WAIT) & ~bus.mem_ready & (cnt_q == TIMEOUT_CNT);
        freeze      = ((state_q == MEM_IDLE) & mem_op & ~bus.mem_ready)
                    | ((state_q == MEM_WAIT) & ~bus.mem_ready & ~timeout_hit);

        state_d    = state_q;
        cnt_d      = cnt_q;
        idex_d     = idex_q;
        exmem_d    = exmem_q;
        memwb_d    = memwb_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (mem_op && !bus.mem_ready) begin
                    state_d = MEM_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready || timeout_hit) begin
                    state_d = MEM_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (freeze) begin
            // Hold EX and MEM; WB gets a bubble so the waiting access is
            // written back only once, when it completes.
            memwb_d    = WB_BUBBLE;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            exmem_d = to_mem(idex_q);
            // An abandoned load must not reach the register file.
            memwb_d = timeout_hit ? WB_BUBBLE : to_wb(exmem_q);
            if (bus.branch_taken) begin
                idex_d     = CTRL_BUBBLE;
                ifid_flush = 1'b1;
            end else if (bus.hazard_stall) begin
                idex_d     = CTRL_BUBBLE;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else begin
                idex_d     = id_ctrl;
            end
        end
    end

    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_aluop     = ALUOP_W'(idex_q.aluop);
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_jump      = idex_q.jump;
    assign bus.ex_illegal   = idex_q.illegal;
    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.mem_busy     = (state_q == MEM_WAIT);
    assign bus.mem_timeout  = timeout_hit;

endmodule
